// File: rtl/display_demultiplex_pkg.sv
// Shared definitions for the 7-segment display bus blocks.
//   - SEG_0..SEG_F / SEG_BLANK : g..a glyph patterns, active high
//   - demux_state_e            : receive FSM state encoding
//   - us_to_ticks()            : microseconds -> clock ticks for a given clock rate
package display_demultiplex_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } demux_state_e;

    function automatic int us_to_ticks(input int clock_hz, input int us);
        return clock_hz / 1_000_000 * us;
    endfunction

endpackage

// File: rtl/display_demultiplex_if.sv
// Display bus as seen by the receiver: raw cathode/segment pins in,
// rebuilt value and status flags out.
//   slave  : the demultiplexer (samples pins, drives results)
//   master : whatever drives the pins and consumes the results
interface display_demultiplex_if;
    logic [7:0]  Cathodes_i;       // one-hot digit select, bit n = digit n
    logic [7:0]  Segments_i;       // [7]=DP, [6:0]=g..a
    logic [31:0] Data_o;           // digit n in [4n+3:4n]
    logic [7:0]  DecimalPoints_o;
    logic [7:0]  Blank_o;
    logic [7:0]  Invalid_o;
    logic        FrameDone_o;
    logic        Active_o;

    modport slave (
        input  Cathodes_i, Segments_i,
        output Data_o, DecimalPoints_o, Blank_o, Invalid_o, FrameDone_o, Active_o
    );

    modport master (
        output Cathodes_i, Segments_i,
        input  Data_o, DecimalPoints_o, Blank_o, Invalid_o, FrameDone_o, Active_o
    );
endinterface

// File: rtl/display_demultiplex_segment_pattern_decoder.sv
// Combinational inverse of the 7-segment hex encoder.
//   seg_i     : g..a pattern (DP excluded)
//   nibble_o  : hex value, 0 when blank or invalid
//   blank_o   : all segments off
//   invalid_o : pattern is not one of the 16 hex glyphs
module segment_pattern_decoder
    import display_demultiplex_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] nibble_o,
    output logic       blank_o,
    output logic       invalid_o
);
    always_comb begin
        nibble_o  = 4'h0;
        blank_o   = 1'b0;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: blank_o   = 1'b1;
            default:   invalid_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/display_demultiplex.sv
// Receive side of the multiplexed 8-digit 7-segment bus. Samples the raw
// cathode/segment pins, waits for a stable dwell on a single digit, and
// rebuilds the 32-bit hex value, DPs and per-digit blank/invalid flags.
//   Clock, Reset (async, active low)
//   bus (slave) : Cathodes_i/Segments_i in; Data_o, DecimalPoints_o,
//                 Blank_o, Invalid_o, FrameDone_o, Active_o out (all registered)
module display_demultiplex
    import display_demultiplex_pkg::*;
#(
    parameter int CLOCK_HZ   = 10_000_000,
    parameter int SETTLE_US  = 50,
    parameter int TIMEOUT_US = 20_000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    display_demultiplex_if.slave  bus
);
    localparam int SETTLE_TICKS  = us_to_ticks(CLOCK_HZ, SETTLE_US);
    localparam int TIMEOUT_TICKS = us_to_ticks(CLOCK_HZ, TIMEOUT_US);
    localparam int SW = $clog2(SETTLE_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [SW-1:0] SET_MAX = SW'(SETTLE_TICKS - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_TICKS - 1);

    // {cathodes, segments}: two sync stages, then a previous-value copy
    logic [15:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    demux_state_e state_q, state_d;
    logic [SW-1:0] set_cnt_q, set_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  dp_q, dp_d, blank_q, blank_d, invalid_q, invalid_d, mask_q, mask_d;
    logic        frame_done_q, frame_done_d, active_q, active_d;

    logic [7:0] cath, seg, new_mask;
    logic       one_hot, any_chg, cath_chg, capture;
    logic [2:0] idx;
    logic [3:0] nibble;
    logic       glyph_blank, glyph_invalid;

    assign cath     = sync2_q[15:8];
    assign seg      = sync2_q[7:0];
    assign one_hot  = $onehot(cath);
    assign any_chg  = (sync2_q != prev_q);
    assign cath_chg = (cath != prev_q[15:8]);

    segment_pattern_decoder u_dec (
        .seg_i     (seg[6:0]),
        .nibble_o  (nibble),
        .blank_o   (glyph_blank),
        .invalid_o (glyph_invalid)
    );

    always_comb begin
        sync1_d = {bus.Cathodes_i, bus.Segments_i};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cath[i]) idx = 3'(i);
        end
    end

    // Receive FSM
    always_comb begin
        state_d   = state_q;
        set_cnt_d = set_cnt_q;
        capture   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (one_hot) begin
                    state_d   = ST_SETTLE;
                    set_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (any_chg) begin
                    set_cnt_d = '0;
                    if (!one_hot) state_d = ST_WAIT;
                end else if (set_cnt_q == SET_MAX) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // Leaving HOLD behaves as WAIT in the same cycle, so a direct
                // switch to another digit starts its settle immediately.
                if (cath_chg) begin
                    if (one_hot) begin
                        state_d   = ST_SETTLE;
                        set_cnt_d = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Capture registers, frame tracking and activity timeout
    always_comb begin
        data_d       = data_q;
        dp_d         = dp_q;
        blank_d      = blank_q;
        invalid_d    = invalid_q;
        mask_d       = mask_q;
        active_d     = active_q;
        frame_done_d = 1'b0;
        new_mask     = mask_q | (8'h01 << idx);
        tmo_cnt_d    = tmo_cnt_q;

        if (capture)                 tmo_cnt_d = '0;
        else if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;

        if (capture) begin
            data_d[4*idx +: 4] = nibble;
            blank_d[idx]       = glyph_blank;
            invalid_d[idx]     = glyph_invalid;
            dp_d[idx]          = seg[7];
            active_d           = 1'b1;
            if (new_mask == 8'hFF) begin
                frame_done_d = 1'b1;
                mask_d       = 8'h00;
            end else begin
                mask_d = new_mask;
            end
        end else if (tmo_cnt_q == TMO_MAX) begin
            // Displayed data is kept; only the partial frame is dropped.
            active_d = 1'b0;
            mask_d   = 8'h00;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            state_q      <= ST_WAIT;
            set_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            data_q       <= '0;
            dp_q         <= '0;
            blank_q      <= 8'hFF;
            invalid_q    <= '0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            set_cnt_q    <= set_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            data_q       <= data_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            invalid_q    <= invalid_d;
            mask_q       <= mask_d;
            frame_done_q <= frame_done_d;
            active_q     <= active_d;
        end
    end

    assign bus.Data_o          = data_q;
    assign bus.DecimalPoints_o = dp_q;
    assign bus.Blank_o         = blank_q;
    assign bus.Invalid_o       = invalid_q;
    assign bus.FrameDone_o     = frame_done_q;
    assign bus.Active_o        = active_q;

endmodule
